x86_alu_encoder: RTL and testbench

//  Encodes one x86 two-operand ALU instruction (ADD/OR/ADC/SBB/AND/SUB/XOR/CMP r/m,reg form)

---
 rtl/x86_alu_encoder.sv | 219 +++++++++++++++++++++
 tb/tb_x86_alu_encoder.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/x86_alu_encoder.sv
// x86_alu_encoder
// Encodes one x86 two-operand ALU instruction (r/m,reg form) into its byte
// stream and writes the bytes, one per cycle, into program RAM over a byte bus.
// Byte order: [segment prefix] opcode ModR/M [disp lo] [disp hi].
// Optional feature macro: ENC_SEG_PREFIX_EN enables the segment-override prefix
// byte (26/2E/36/3E); when undefined the prefix state does not exist and
// req_seg is ignored.
module x86_alu_encoder #(
    parameter logic [15:0] BASE_ADDR = 16'h0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        locked,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_alu,
    input  logic        req_size,
    input  logic        req_dir,
    input  logic [1:0]  req_mod,
    input  logic [2:0]  req_reg,
    input  logic [2:0]  req_rm,
    input  logic [15:0] req_disp,
    input  logic [2:0]  req_seg,
    input  logic        ptr_load,
    input  logic [15:0] ptr_value,
    output logic [15:0] address,
    output logic [7:0]  out,
    output logic        we,
    output logic        busy,
    output logic        done,
    output logic [2:0]  inst_len
);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_OPCODE  = 3'd1;
    localparam logic [2:0] ST_MODRM   = 3'd2;
    localparam logic [2:0] ST_DISP_LO = 3'd3;
    localparam logic [2:0] ST_DISP_HI = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;
`ifdef ENC_SEG_PREFIX_EN
    localparam logic [2:0] ST_PREFIX  = 3'd6;
`endif

    logic [2:0]  state_q, state_d;
    logic [15:0] ptr_q, ptr_d;
    logic [2:0]  alu_q, alu_d;
    logic        size_q, size_d;
    logic        dir_q, dir_d;
    logic [1:0]  mod_q, mod_d;
    logic [2:0]  reg_q, reg_d;
    logic [2:0]  rm_q, rm_d;
    logic [15:0] disp_q, disp_d;
    logic [2:0]  inst_len_q, inst_len_d;
    logic        pfx_q, pfx_d;
`ifdef ENC_SEG_PREFIX_EN
    logic [1:0]  seg_q, seg_d;
`else
    // req_seg has no function in this build; folded here so it is visibly unused.
    logic        unused_seg;
    assign unused_seg = ^req_seg;
`endif

    logic [1:0]  disp_cnt;
    logic [2:0]  len_total;
    logic        emit;
    logic [7:0]  emit_byte;

    // Number of displacement bytes implied by the latched mod/rm (16-bit addressing).
    always_comb begin
        disp_cnt = 2'd0;
        case (mod_q)
            2'b00:   disp_cnt = (rm_q == 3'b110) ? 2'd2 : 2'd0;
            2'b01:   disp_cnt = 2'd1;
            2'b10:   disp_cnt = 2'd2;
            default: disp_cnt = 2'd0;
        endcase
        len_total = 3'd2 + {1'b0, disp_cnt} + {2'b00, pfx_q};
    end

    // Moore decode of the byte presented on the bus in each emit state.
    always_comb begin
        emit      = 1'b0;
        emit_byte = 8'h00;
        case (state_q)
`ifdef ENC_SEG_PREFIX_EN
            ST_PREFIX: begin
                emit      = 1'b1;
                emit_byte = {3'b001, seg_q, 3'b110};
            end
`endif
            ST_OPCODE: begin
                emit      = 1'b1;
                emit_byte = {2'b00, alu_q, 1'b0, dir_q, size_q};
            end
            ST_MODRM: begin
                emit      = 1'b1;
                emit_byte = {mod_q, reg_q, rm_q};
            end
            ST_DISP_LO: begin
                emit      = 1'b1;
                emit_byte = disp_q[7:0];
            end
            ST_DISP_HI: begin
                emit      = 1'b1;
                emit_byte = disp_q[15:8];
            end
            default: begin
                emit      = 1'b0;
                emit_byte = 8'h00;
            end
        endcase
    end

    assign we        = emit & locked;
    assign out       = emit ? emit_byte : 8'h00;
    assign address   = ptr_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = locked & (state_q == ST_DONE);
    assign inst_len  = inst_len_q;
    // Gated by reset_n so no handshake can complete while reset is asserted.
    assign req_ready = reset_n & locked & (state_q == ST_IDLE) & ~ptr_load;

    // Next-state, pointer and request-latch logic; everything holds while unlocked.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        alu_d      = alu_q;
        size_d     = size_q;
        dir_d      = dir_q;
        mod_d      = mod_q;
        reg_d      = reg_q;
        rm_d       = rm_q;
        disp_d     = disp_q;
        inst_len_d = inst_len_q;
        pfx_d      = pfx_q;
`ifdef ENC_SEG_PREFIX_EN
        seg_d      = seg_q;
`endif
        if (locked) begin
            case (state_q)
                ST_IDLE: begin
                    // A pointer load wins over a request presented in the same cycle.
                    if (ptr_load) begin
                        ptr_d = ptr_value;
                    end else if (req_valid) begin
                        alu_d  = req_alu;
                        size_d = req_size;
                        dir_d  = req_dir;
                        mod_d  = req_mod;
                        reg_d  = req_reg;
                        rm_d   = req_rm;
                        disp_d = req_disp;
`ifdef ENC_SEG_PREFIX_EN
                        seg_d   = req_seg[1:0];
                        pfx_d   = req_seg[2];
                        state_d = req_seg[2] ? ST_PREFIX : ST_OPCODE;
`else
                        pfx_d   = 1'b0;
                        state_d = ST_OPCODE;
`endif
                    end
                end
`ifdef ENC_SEG_PREFIX_EN
                ST_PREFIX:  state_d = ST_OPCODE;
`endif
                ST_OPCODE:  state_d = ST_MODRM;
                ST_MODRM:   state_d = (disp_cnt == 2'd0) ? ST_DONE : ST_DISP_LO;
                ST_DISP_LO: state_d = (disp_cnt == 2'd2) ? ST_DISP_HI : ST_DONE;
                ST_DISP_HI: state_d = ST_DONE;
                ST_DONE:    state_d = ST_IDLE;
                default:    state_d = ST_IDLE;
            endcase
            // One address step per byte actually written; wraps naturally at 16 bits.
            if (emit) begin
                ptr_d = ptr_q + 16'd1;
            end
            // Length becomes visible in the same cycle as the done pulse.
            if (emit && (state_d == ST_DONE)) begin
                inst_len_d = len_total;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= BASE_ADDR;
            alu_q      <= 3'd0;
            size_q     <= 1'b0;
            dir_q      <= 1'b0;
            mod_q      <= 2'd0;
            reg_q      <= 3'd0;
            rm_q       <= 3'd0;
            disp_q     <= 16'h0000;
            inst_len_q <= 3'd0;
            pfx_q      <= 1'b0;
`ifdef ENC_SEG_PREFIX_EN
            seg_q      <= 2'd0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            alu_q      <= alu_d;
            size_q     <= size_d;
            dir_q      <= dir_d;
            mod_q      <= mod_d;
            reg_q      <= reg_d;
            rm_q       <= rm_d;
            disp_q     <= disp_d;
            inst_len_q <= inst_len_d;
            pfx_q      <= pfx_d;
`ifdef ENC_SEG_PREFIX_EN
            seg_q      <= seg_d;
`endif
        end
    end

endmodule

// File: tb/tb_x86_alu_encoder.sv
// Directed testbench for x86_alu_encoder (BASE_ADDR = 0100).
module tb_x86_alu_encoder;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        locked = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_alu = 3'd0;
    logic        req_size = 1'b0;
    logic        req_dir = 1'b0;
    logic [1:0]  req_mod = 2'd0;
    logic [2:0]  req_reg = 3'd0;
    logic [2:0]  req_rm = 3'd0;
    logic [15:0] req_disp = 16'h0000;
    logic [2:0]  req_seg = 3'd0;
    logic        ptr_load = 1'b0;
    logic [15:0] ptr_value = 16'h0000;
    logic [15:0] address;
    logic [7:0]  out;
    logic        we;
    logic        busy;
    logic        done;
    logic [2:0]  inst_len;

    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;

    int wr_addr[$];
    int wr_data[$];
    int wr_cyc[$];
    int done_cyc[$];
    int done_len[$];

    x86_alu_encoder #(.BASE_ADDR(16'h0100)) dut (
        .clock(clock), .reset_n(reset_n), .locked(locked),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_alu(req_alu), .req_size(req_size), .req_dir(req_dir),
        .req_mod(req_mod), .req_reg(req_reg), .req_rm(req_rm),
        .req_disp(req_disp), .req_seg(req_seg),
        .ptr_load(ptr_load), .ptr_value(ptr_value),
        .address(address), .out(out), .we(we),
        .busy(busy), .done(done), .inst_len(inst_len)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Bus monitor: log every written byte and every done pulse.
    always @(negedge clock) begin
        if (we === 1'b1) begin
            wr_addr.push_back(int'(address));
            wr_data.push_back(int'(out));
            wr_cyc.push_back(cyc);
            $display("[%0d] write %02h @ %04h", cyc, out, address);
        end
        if (done === 1'b1) begin
            done_cyc.push_back(cyc);
            done_len.push_back(int'(inst_len));
            $display("[%0d] done len=%0d", cyc, inst_len);
        end
    end

    task automatic clear_logs();
        wr_addr.delete(); wr_data.delete(); wr_cyc.delete();
        done_cyc.delete(); done_len.delete();
    endtask

    task automatic issue(input logic [2:0] alu, input logic sz, input logic dr,
                         input logic [1:0] md, input logic [2:0] rg, input logic [2:0] rm,
                         input logic [15:0] disp, input logic [2:0] seg,
                         output int acc, output bit ok);
        @(negedge clock);
        req_alu = alu; req_size = sz; req_dir = dr; req_mod = md;
        req_reg = rg; req_rm = rm; req_disp = disp; req_seg = seg;
        req_valid = 1'b1;
        ok = 1'b0;
        acc = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (req_ready === 1'b1) begin
                @(posedge clock);
                #1;
                acc = cyc;
                ok = 1'b1;
                break;
            end
            @(negedge clock);
        end
        req_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL accept: request not accepted, got timeout, required accept");
        else n_pass++;
    endtask

    task automatic wait_done(input int n);
        bit ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            #1;
            if (done_cyc.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!ok) $display("FAIL done_timeout: got %0d done pulses, required %0d", done_cyc.size(), n);
        else n_pass++;
    endtask

    task automatic check_writes(input string name, input int exp_a[], input int exp_d[]);
        n_checks++;
        if (wr_addr.size() != exp_a.size())
            $display("FAIL %s_count: got %0d writes, required %0d", name, wr_addr.size(), exp_a.size());
        else n_pass++;
        for (int i = 0; i < exp_a.size(); i++) begin
            int ga = (i < wr_addr.size()) ? wr_addr[i] : -1;
            int gd = (i < wr_data.size()) ? wr_data[i] : -1;
            n_checks++;
            if (ga !== exp_a[i] || gd !== exp_d[i])
                $display("FAIL %s_byte%0d: got %02h@%04h, required %02h@%04h",
                         name, i, gd, ga, exp_d[i], exp_a[i]);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        locked = 1'b1;
        repeat (2) @(negedge clock);
        n_checks++;
        if (req_ready !== 1'b0 || we !== 1'b0 || out !== 8'h00 || busy !== 1'b0 ||
            done !== 1'b0 || inst_len !== 3'd0 || address !== 16'h0100)
            $display("FAIL reset_state: got rdy=%b we=%b out=%02h busy=%b done=%b len=%0d addr=%04h, required 0 0 00 0 0 0 0100",
                     req_ready, we, out, busy, done, inst_len, address);
        else n_pass++;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL ready_after_reset: got %b, required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_reg_form();
        int acc; bit ok;
        clear_logs();
        issue(3'd0, 1'b0, 1'b0, 2'b11, 3'd3, 3'd0, 16'h0000, 3'b000, acc, ok);
        wait_done(1);
        check_writes("reg_form", '{16'h0100, 16'h0101}, '{8'h00, 8'hD8});
        n_checks++;
        if (wr_cyc.size() != 2 || wr_cyc[0] != acc || wr_cyc[1] != acc + 1)
            $display("FAIL reg_form_latency: got first write cycle %0d, required %0d", (wr_cyc.size() > 0) ? wr_cyc[0] : -1, acc);
        else n_pass++;
        n_checks++;
        if (done_cyc[0] != acc + 2 || done_len[0] != 2)
            $display("FAIL reg_form_done: got cyc %0d len %0d, required cyc %0d len 2", done_cyc[0], done_len[0], acc + 2);
        else n_pass++;
        n_checks++;
        if (address !== 16'h0102) $display("FAIL reg_form_ptr: got %04h, required 0102", address);
        else n_pass++;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reg_form_idle: got busy=%b done=%b, required 0 0", busy, done);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int acc1, acc2; bit ok;
        clear_logs();
        issue(3'd5, 1'b1, 1'b1, 2'b01, 3'd1, 3'd6, 16'h00F0, 3'b000, acc1, ok);
        issue(3'd7, 1'b1, 1'b0, 2'b00, 3'd0, 3'd6, 16'h1234, 3'b000, acc2, ok);
        wait_done(2);
        check_writes("b2b",
                     '{16'h0102, 16'h0103, 16'h0104, 16'h0105, 16'h0106, 16'h0107, 16'h0108},
                     '{8'h2B, 8'h4E, 8'hF0, 8'h39, 8'h06, 8'h34, 8'h12});
        n_checks++;
        if (acc2 - acc1 != 5) $display("FAIL b2b_throughput: got %0d cycles, required 5", acc2 - acc1);
        else n_pass++;
        n_checks++;
        if (done_len[0] != 3 || done_len[1] != 4)
            $display("FAIL b2b_len: got %0d,%0d, required 3,4", done_len[0], done_len[1]);
        else n_pass++;
        n_checks++;
        if (done_cyc[0] != acc1 + 3 || done_cyc[1] != acc2 + 4)
            $display("FAIL b2b_done_cycle: got %0d,%0d, required %0d,%0d", done_cyc[0], done_cyc[1], acc1 + 3, acc2 + 4);
        else n_pass++;
    endtask

    task automatic test_ptr_load_wrap();
        int acc; bit ok;
        clear_logs();
        @(negedge clock);
        ptr_load = 1'b1; ptr_value = 16'hFFFF;
        req_alu = 3'd1; req_size = 1'b0; req_dir = 1'b1; req_mod = 2'b10;
        req_reg = 3'd2; req_rm = 3'd7; req_disp = 16'hABCD; req_seg = 3'b000;
        req_valid = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b0) $display("FAIL ptr_load_ready: got %b, required 0", req_ready);
        else n_pass++;
        @(posedge clock);
        #1;
        ptr_load = 1'b0;
        req_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || address !== 16'hFFFF)
            $display("FAIL ptr_load_priority: got busy=%b addr=%04h, required 0 FFFF", busy, address);
        else n_pass++;
        issue(3'd1, 1'b0, 1'b1, 2'b10, 3'd2, 3'd7, 16'hABCD, 3'b000, acc, ok);
        wait_done(1);
        check_writes("wrap", '{16'hFFFF, 16'h0000, 16'h0001, 16'h0002}, '{8'h0A, 8'h97, 8'hCD, 8'hAB});
        n_checks++;
        if (done_len[0] != 4) $display("FAIL wrap_len: got %0d, required 4", done_len[0]);
        else n_pass++;
        // ptr_load while busy must be ignored
        issue(3'd0, 1'b0, 1'b0, 2'b11, 3'd0, 3'd0, 16'h0000, 3'b000, acc, ok);
        ptr_load = 1'b1; ptr_value = 16'h4444;
        wait_done(2);
        ptr_load = 1'b0;
        n_checks++;
        if (address !== 16'h0005) $display("FAIL ptr_load_busy: got %04h, required 0005", address);
        else n_pass++;
    endtask

    task automatic test_locked_and_reset();
        int acc; bit ok;
        clear_logs();
        issue(3'd2, 1'b1, 1'b0, 2'b01, 3'd4, 3'd2, 16'h0080, 3'b000, acc, ok);
        @(posedge clock);
        #1;
        locked = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (we !== 1'b0 || address !== 16'h0006 || req_ready !== 1'b0 || busy !== 1'b1 || done !== 1'b0)
                $display("FAIL stall%0d: got we=%b addr=%04h rdy=%b busy=%b done=%b, required 0 0006 0 1 0",
                         i, we, address, req_ready, busy, done);
            else n_pass++;
            @(posedge clock);
        end
        #1;
        locked = 1'b1;
        wait_done(1);
        check_writes("stall", '{16'h0005, 16'h0006, 16'h0007}, '{8'h11, 8'h62, 8'h80});
        n_checks++;
        if (done_len[0] != 3) $display("FAIL stall_len: got %0d, required 3", done_len[0]);
        else n_pass++;

        // Reset mid-displacement.
        clear_logs();
        issue(3'd4, 1'b0, 1'b0, 2'b10, 3'd0, 3'd0, 16'h5566, 3'b000, acc, ok);
        @(posedge clock);
        @(posedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (we !== 1'b0 || address !== 16'h0100 || busy !== 1'b0 || done !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL mid_reset: got we=%b addr=%04h busy=%b done=%b rdy=%b, required 0 0100 0 0 0",
                     we, address, busy, done, req_ready);
        else n_pass++;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        check_writes("mid_reset", '{16'h0008, 16'h0009}, '{8'h20, 8'h80});
        n_checks++;
        if (done_cyc.size() != 0 || inst_len !== 3'd0)
            $display("FAIL mid_reset_done: got %0d pulses len=%0d, required 0 pulses len=0", done_cyc.size(), inst_len);
        else n_pass++;
    endtask

    task automatic test_seg_prefix();
        int acc; bit ok;
        clear_logs();
        issue(3'd6, 1'b0, 1'b0, 2'b11, 3'd1, 3'd2, 16'h0000, 3'b101, acc, ok);
        wait_done(1);
`ifdef ENC_SEG_PREFIX_EN
        check_writes("seg", '{16'h0100, 16'h0101, 16'h0102}, '{8'h2E, 8'h30, 8'hCA});
        n_checks++;
        if (done_len[0] != 3) $display("FAIL seg_len: got %0d, required 3", done_len[0]);
        else n_pass++;
`else
        check_writes("seg", '{16'h0100, 16'h0101}, '{8'h30, 8'hCA});
        n_checks++;
        if (done_len[0] != 2) $display("FAIL seg_len: got %0d, required 2", done_len[0]);
        else n_pass++;
`endif
    endtask

    initial begin
        test_reset();
        test_reg_form();
        test_back_to_back();
        test_ptr_load_wrap();
        test_locked_and_reset();
        test_seg_prefix();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
